// File: rtl/reduction_table_loader.sv
// Streams 32-bit beats into wide table words and writes them into one of two
// block RAMs: a 256-bit coarse/fold constant table or a 260-bit fine-grain table.
// A load is described by target, base address and word count. It is range-checked
// before any beat is accepted, and it is terminated early, with the sticky error
// flag set, if s_last arrives on a beat that is not the last beat of the load.
module reduction_table_loader #(
    parameter int BEAT_W = 32,
    parameter int T1_W   = 256,
    parameter int T2_W   = 260
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic              cfg_tgt,
    input  logic [10:0]       cfg_base,
    input  logic [11:0]       cfg_count,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [BEAT_W-1:0] s_data,
    input  logic              s_last,
    output logic              b1_en,
    output logic              b1_we,
    output logic [10:0]       b1_addr,
    output logic [T1_W-1:0]   b1_din,
    output logic              b2_en,
    output logic              b2_we,
    output logic [3:0]        b2_addr,
    output logic [T2_W-1:0]   b2_din,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [11:0]       words_written
);

    // Width of the partial top beat of a fine-grain word (4 bits by default).
    localparam int TOP_W = T2_W - 8 * BEAT_W;

    typedef enum logic [2:0] {IDLE, CHECK, COLLECT, WRITE, FINISH} state_t;

    state_t           state_q, state_d;
    logic             tgt_q, tgt_d;
    logic [10:0]      addr_q, addr_d;
    logic [11:0]      count_q, count_d;
    logic [3:0]       beat_q, beat_d;
    logic [T2_W-1:0]  word_q, word_d;
    logic [11:0]      words_q, words_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             s_ready_q, s_ready_d;
    logic             b1_en_q, b1_en_d;
    logic [10:0]      b1_addr_q, b1_addr_d;
    logic [T1_W-1:0]  b1_din_q, b1_din_d;
    logic             b2_en_q, b2_en_d;
    logic [3:0]       b2_addr_q, b2_addr_d;
    logic [T2_W-1:0]  b2_din_q, b2_din_d;

    logic             last_beat;
    logic             final_word;
    logic             illegal;

    // Next-state, beat packing and registered-output computation.
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        addr_d    = addr_q;
        count_d   = count_q;
        beat_d    = beat_q;
        word_d    = word_q;
        words_d   = words_q;
        err_d     = err_q;
        b1_en_d   = 1'b0;
        b1_addr_d = b1_addr_q;
        b1_din_d  = b1_din_q;
        b2_en_d   = 1'b0;
        b2_addr_d = b2_addr_q;
        b2_din_d  = b2_din_q;

        last_beat  = (beat_q == (tgt_q ? 4'd8 : 4'd7));
        final_word = (({1'b0, words_q} + 13'd1) == {1'b0, count_q});
        if (tgt_q)
            illegal = (count_q == 12'd0) ||
                      (({9'd0, addr_q[3:0]} + {1'b0, count_q}) > 13'd16);
        else
            illegal = (count_q == 12'd0) ||
                      (({2'd0, addr_q} + {1'b0, count_q}) > 13'd2048);

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    tgt_d   = cfg_tgt;
                    addr_d  = cfg_tgt ? {7'd0, cfg_base[3:0]} : cfg_base;
                    count_d = cfg_count;
                    err_d   = 1'b0;
                    words_d = 12'd0;
                    beat_d  = 4'd0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (illegal) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (s_valid && s_ready_q) begin
                    // Little-endian packing: beat k lands in bits [32k+31:32k].
                    for (int k = 0; k < 8; k++) begin
                        if (beat_q == 4'(k))
                            word_d[k*BEAT_W +: BEAT_W] = s_data;
                    end
                    if (beat_q == 4'd8)
                        word_d[T2_W-1 -: TOP_W] = s_data[TOP_W-1:0];

                    if (last_beat && final_word) begin
                        // Last word is written even without s_last, but flagged.
                        if (!s_last)
                            err_d = 1'b1;
                        state_d = WRITE;
                    end else if (s_last) begin
                        // Early terminator: drop the word being assembled.
                        err_d   = 1'b1;
                        beat_d  = 4'd0;
                        state_d = FINISH;
                    end else if (last_beat) begin
                        state_d = WRITE;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            WRITE: begin
                addr_d  = addr_q + 11'd1;
                words_d = words_q + 12'd1;
                beat_d  = 4'd0;
                if (final_word)
                    state_d = FINISH;
                else
                    state_d = COLLECT;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The write strobe is registered so it coincides with the WRITE cycle.
        if (state_q == COLLECT && state_d == WRITE) begin
            if (tgt_q) begin
                b2_en_d   = 1'b1;
                b2_addr_d = addr_q[3:0];
                b2_din_d  = word_d;
            end else begin
                b1_en_d   = 1'b1;
                b1_addr_d = addr_q;
                b1_din_d  = word_d[T1_W-1:0];
            end
        end

        busy_d    = (state_d != IDLE);
        s_ready_d = (state_d == COLLECT);
        done_d    = (state_d == FINISH);
    end

    // Single state/output register bank; reset returns everything to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tgt_q     <= 1'b0;
            addr_q    <= '0;
            count_q   <= '0;
            beat_q    <= '0;
            word_q    <= '0;
            words_q   <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            s_ready_q <= 1'b0;
            b1_en_q   <= 1'b0;
            b1_addr_q <= '0;
            b1_din_q  <= '0;
            b2_en_q   <= 1'b0;
            b2_addr_q <= '0;
            b2_din_q  <= '0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            beat_q    <= beat_d;
            word_q    <= word_d;
            words_q   <= words_d;
            err_q     <= err_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            s_ready_q <= s_ready_d;
            b1_en_q   <= b1_en_d;
            b1_addr_q <= b1_addr_d;
            b1_din_q  <= b1_din_d;
            b2_en_q   <= b2_en_d;
            b2_addr_q <= b2_addr_d;
            b2_din_q  <= b2_din_d;
        end
    end

    assign s_ready       = s_ready_q;
    assign b1_en         = b1_en_q;
    assign b1_we         = b1_en_q;
    assign b1_addr       = b1_addr_q;
    assign b1_din        = b1_din_q;
    assign b2_en         = b2_en_q;
    assign b2_we         = b2_en_q;
    assign b2_addr       = b2_addr_q;
    assign b2_din        = b2_din_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign words_written = words_q;

endmodule

// File: doc/reduction_table_loader.md
REDUCTION_TABLE_LOADER -- requirements
Module: reduction_table_loader

Interface
REQ-001 Parameter: BEAT_W, 32, stream beat width in bits.
REQ-002 Parameter: T1_W, 256, word width of the coarse-grain/fold constant table (BRAM1).
REQ-003 Parameter: T2_W, 260, word width of the fine-grain table (BRAM2).
REQ-004 Ports, name direction width meaning:
- clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
- rst  in  1  synchronous active-high reset.
- cfg_start  in  1  single-cycle pulse; begins a load.
- cfg_tgt  in  1  0 = BRAM1 table, 1 = BRAM2 table.
- cfg_base  in  11  first word address; only bits [3:0] are used when cfg_tgt=1.
- cfg_count  in  12  number of table words to write.
- s_valid  in  1  stream beat valid.
- s_ready  out  1  stream beat ready.
- s_data  in  32  beat payload.
- s_last  in  1  marks the final beat of the load.
- b1_en, b1_we  out  1 each  BRAM1 write enable pair.
- b1_addr  out  11  BRAM1 address.
- b1_din  out  256  BRAM1 write data.
- b2_en, b2_we  out  1 each  BRAM2 write enable pair.
- b2_addr  out  4  BRAM2 address.
- b2_din  out  260  BRAM2 write data.
- busy  out  1  load in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky error flag; cleared on next accepted cfg_start.
- words_written  out  12  count of table words written in the current/last load.

Function
REQ-005 States: IDLE, CHECK, COLLECT, WRITE, FINISH.
REQ-006 IDLE: s_ready=0, busy=0; cfg_start latches tgt/base/count, clears err and words_written, and moves to CHECK.
REQ-007 cfg_start is ignored while busy=1.
REQ-008 CHECK (1 cycle): the load is illegal if count==0, or tgt=0 and base+count>2048, or tgt=1 and base[3:0]+count>16; illegal -> err=1, go to FINISH with no writes and s_ready never asserted; legal -> go to COLLECT.
REQ-009 COLLECT: s_ready=1; a beat transfers when s_valid&s_ready.
- Beats per word: 8 for tgt=0, 9 for tgt=1.
- Packing is little-endian: beat k fills bits [32k+31:32k].
- On the 9th beat for tgt=1, only s_data[3:0] is used, for bits [259:256]; s_data[31:4] is ignored.
REQ-010 After the final beat of a word, go to WRITE.
REQ-011 WRITE (exactly 1 cycle):
- s_ready=0.
- The selected port drives en=we=1 with the current address and assembled word; the other port is idle.
- Then: address+1, words_written+1, beat counter cleared.
- Next state: COLLECT if words remain, else FINISH.
REQ-012 The write ports drive en=we=0 in every cycle other than WRITE, and address/data outputs hold their last value.
REQ-013 Throughput: one word per (beats+1) cycles with continuous s_valid; idle s_valid cycles stall without data loss.
REQ-014 s_last on a beat that is not the final beat of the final word: accept the beat, discard the partial word, set err=1, go to FINISH.
REQ-015 Final beat of the final word transferred without s_last: the word is still written; err=1.
REQ-016 FINISH (1 cycle): done=1, busy=0 next, return to IDLE; words_written holds its value until the next start.
REQ-017 busy=1 from the cycle after cfg_start is accepted until the FINISH cycle inclusive.

Reset
REQ-018 rst takes priority over all inputs and forces IDLE.
REQ-019 rst clears every output to 0, including b1_addr, b1_din, b2_addr, b2_din, err and words_written.
REQ-020 rst mid-load: no write is asserted in the cycle following reset, and the partial word is discarded.

Verification
REQ-021 tgt=0, base=1664, count=3, 24 beats of value n (beat index), s_last on beat 24 -> three BRAM1 writes to 1664/1665/1666; word0 = {7,6,...,0}; done pulse; err=0; words_written=3.
REQ-022 tgt=1, base=0, count=16, 144 beats, beat 9 of each word = 0xFFFFFFF5 -> 16 BRAM2 writes to addresses 0..15, each with b2_din[259:256]=4'h5; err=0.
REQ-023 tgt=0, base=2047, count=2 -> err=1, done exactly 2 cycles after cfg_start, zero writes, s_ready stays 0.
REQ-024 tgt=0, count=3, s_last on beat 5 of word 2 -> exactly one write, err=1, done, words_written=1.
REQ-025 Repeat REQ-021 with s_valid randomly deasserted 50% of cycles -> identical writes; no write issued while s_ready=0 beats are pending.
REQ-026 rst asserted after beat 10 of REQ-021 -> all outputs 0 on the next cycle, no write; a subsequent REQ-021 load completes correctly.
